// File: rtl/mtt_walk_arbiter_pkg.sv
// Shared types for the MPT walker arbiter: walker error codes, arbiter FSM states
// and the registered response bundle returned to the owning requester.
package mtt_walk_arbiter_pkg;

   typedef enum logic [1:0] {
      NO_ERROR           = 2'd0,
      NOT_VALID_ADDR     = 2'd1,
      NOT_VALID_MPTL3E   = 2'd2,
      RESERVED_BITS_USED = 2'd3
   } error_t;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_WAIT    = 3'd2,
      ST_RESP    = 3'd3,
      ST_RESP_TO = 3'd4,
      ST_FLUSH   = 3'd5
   } arb_state_e;

   localparam int unsigned MTT_ARB_TIMEOUT_DEFAULT = 256;

   typedef struct packed {
      logic        allow;
      logic        fault;
      logic        timeout;
      error_t      error;
      logic [63:0] tlb_entry;
   } rsp_t;

endpackage

// File: rtl/mtt_rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after ptr_i, wrapping.
// Zero latency; the parent owns the pointer and decides when a grant is taken.
module mtt_rr_arbiter #(
   parameter  int unsigned NUM_REQ = 3,
   localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic               any_o
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      cand  = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         cand = IDX_W'((32'(ptr_i) + k) % NUM_REQ);
         if (!any_o && req_i[cand]) begin
            any_o       = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
         end
      end
   end

endmodule

// File: rtl/mtt_walk_arbiter.sv
// Shares one MPT walker among NUM_REQ requesters, one check at a time, round-robin.
// Grant->enable 1 cycle, response 1 cycle after walker completion; busy walker or flush blocks grants.
module mtt_walk_arbiter
   import mtt_walk_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 3,
   parameter int unsigned ADDR_LEN       = 56,
   parameter int unsigned TIMEOUT_CYCLES = MTT_ARB_TIMEOUT_DEFAULT
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         flush_i,
   input  logic [NUM_REQ-1:0]           req_valid_i,
   output logic [NUM_REQ-1:0]           req_ready_o,
   input  logic [NUM_REQ*ADDR_LEN-1:0]  req_paddr_i,
   input  logic [NUM_REQ*3-1:0]         req_access_i,
   output logic [NUM_REQ-1:0]           rsp_valid_o,
   output logic                         rsp_allow_o,
   output logic                         rsp_fault_o,
   output logic                         rsp_timeout_o,
   output logic [1:0]                   rsp_error_o,
   output logic [63:0]                  rsp_tlb_entry_o,
   output logic                         walk_enable_o,
   output logic                         walk_addr_valid_o,
   output logic                         walk_flush_o,
   output logic [ADDR_LEN-1:0]          walk_paddr_o,
   output logic [2:0]                   walk_access_o,
   input  logic                         walk_busy_i,
   input  logic                         walk_valid_i,
   input  logic                         walk_allow_i,
   input  logic                         walk_fault_i,
   input  logic [1:0]                   walk_error_i,
   input  logic [63:0]                  walk_tlb_entry_i
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   arb_state_e          state_q, state_d;
   logic [IDX_W-1:0]    ptr_q, ptr_d;
   logic [IDX_W-1:0]    owner_q, owner_d;
   logic [ADDR_LEN-1:0] paddr_q, paddr_d;
   logic [2:0]          access_q, access_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   rsp_t                rsp_q, rsp_d;

   logic [NUM_REQ-1:0]  gnt;
   logic [IDX_W-1:0]    gnt_idx;
   logic                gnt_any;
   logic                grant;

   mtt_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req_i (req_valid_i),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .idx_o (gnt_idx),
      .any_o (gnt_any)
   );

   assign grant = (state_q == ST_IDLE) && !rst_i && !flush_i && !walk_busy_i && gnt_any;

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      owner_d  = owner_q;
      paddr_d  = paddr_q;
      access_d = access_q;
      cnt_d    = cnt_q;
      rsp_d    = rsp_q;
      // Flush leaves all captured state untouched so an aborted result never leaks out.
      if (flush_i) begin
         state_d = ST_FLUSH;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (grant) begin
                  paddr_d  = req_paddr_i[32'(gnt_idx)*ADDR_LEN +: ADDR_LEN];
                  access_d = req_access_i[32'(gnt_idx)*3 +: 3];
                  owner_d  = gnt_idx;
                  ptr_d    = gnt_idx;
                  state_d  = ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               cnt_d   = '0;
               state_d = ST_WAIT;
            end
            ST_WAIT: begin
               if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
               if (walk_valid_i || walk_fault_i) begin
                  rsp_d.allow     = walk_allow_i && !walk_fault_i;
                  rsp_d.fault     = walk_fault_i;
                  rsp_d.timeout   = 1'b0;
                  rsp_d.error     = error_t'(walk_error_i);
                  rsp_d.tlb_entry = walk_tlb_entry_i;
                  state_d         = ST_RESP;
               end else if (cnt_q == CNT_LAST) begin
                  rsp_d.allow     = 1'b0;
                  rsp_d.fault     = 1'b1;
                  rsp_d.timeout   = 1'b1;
                  rsp_d.error     = NO_ERROR;
                  rsp_d.tlb_entry = '0;
                  state_d         = ST_RESP_TO;
               end
            end
            ST_RESP:    state_d = ST_IDLE;
            ST_RESP_TO: state_d = ST_FLUSH;
            ST_FLUSH:   state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         ptr_q    <= IDX_W'(NUM_REQ - 1);
         owner_q  <= '0;
         paddr_q  <= '0;
         access_q <= '0;
         cnt_q    <= '0;
         rsp_q    <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         paddr_q  <= paddr_d;
         access_q <= access_d;
         cnt_q    <= cnt_d;
         rsp_q    <= rsp_d;
      end
   end

   assign req_ready_o       = grant ? gnt : '0;
   assign walk_enable_o     = (state_q == ST_ISSUE) && !flush_i;
   assign walk_addr_valid_o = (state_q == ST_ISSUE) && !flush_i;
   assign walk_flush_o      = (state_q == ST_FLUSH);
   assign walk_paddr_o      = paddr_q;
   assign walk_access_o     = access_q;
   assign rsp_valid_o       = ((state_q == ST_RESP || state_q == ST_RESP_TO) && !flush_i)
                              ? (NUM_REQ'(1) << owner_q) : '0;
   assign rsp_allow_o       = rsp_q.allow;
   assign rsp_fault_o       = rsp_q.fault;
   assign rsp_timeout_o     = rsp_q.timeout;
   assign rsp_error_o       = rsp_q.error;
   assign rsp_tlb_entry_o   = rsp_q.tlb_entry;

endmodule
